// File: rtl/blvds_frame_check_if.sv
// blvds_frame_check_if -- word stream in from the BLVDS deserializer and
// payload write port out to the downstream FIFO.
//
// Handshake: a word on iDATA is consumed on every iCLK edge where
// iDATA_VALID=1 (there is no back-pressure toward the deserializer).
// iFIFO_FULL is a level from the FIFO; a payload word is written only if
// iFIFO_FULL=0 in the cycle it arrives.  oFIFO_WR is a one-cycle strobe
// qualifying oFIFO_DATA in the same cycle.
interface blvds_frame_check_if;
   logic [15:0] iDATA;
   logic        iDATA_VALID;
   logic        iFIFO_FULL;
   logic [15:0] oFIFO_DATA;
   logic        oFIFO_WR;

   // Source side: deserializer plus FIFO status.
   modport master (
      output iDATA, iDATA_VALID, iFIFO_FULL,
      input  oFIFO_DATA, oFIFO_WR
   );

   // Frame checker side.
   modport slave (
      input  iDATA, iDATA_VALID, iFIFO_FULL,
      output oFIFO_DATA, oFIFO_WR
   );
endinterface

// File: rtl/blvds_frame_check.sv
// blvds_frame_check -- checks BLVDS frames of the form
//   HEAD_WORD, PAYLOAD_LEN payload words, EPILOG_WORD
// and forwards payload words to a FIFO.  Header/epilog mismatches and
// payload words lost to a full FIFO are reported as one-cycle pulses.
// Optional feature: define BLVDS_FRAME_CHECK_STAT_EN to add oFRAME_CNT,
// a saturating count of cleanly completed frames.
module blvds_frame_check #(
   parameter logic [15:0] HEAD_WORD   = 16'hA5A5,
   parameter logic [15:0] EPILOG_WORD = 16'h5A5A,
   parameter int          PAYLOAD_LEN = 256
) (
   input  logic                      iCLK,
   input  logic                      iRST_N,
   input  logic                      iSOFT_RST,
   blvds_frame_check_if.slave        bus,
   output logic                      oFRAME_DONE,
   output logic                      oFULL_ERROR,
   output logic                      oHEAD_ERROR,
   output logic                      oEPILOG_ERROR,
   output logic                      oBUSY,
`ifdef BLVDS_FRAME_CHECK_STAT_EN
   output logic [15:0]               oFRAME_CNT,
`endif
   output logic [1:0]                oDBG_STATE
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      DROP    = 2'd2,
      EPILOG  = 2'd3
   } state_t;

   // Counter value of the last payload word in a frame.
   localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_LEN - 1);

   state_t      state;
   logic [15:0] wordCnt;
   logic        dropFlag;
   logic        lastWord;

   assign lastWord   = (wordCnt == LAST_IDX);
   assign oBUSY      = (state != IDLE);
   assign oDBG_STATE = state;

   // Frame FSM with registered FIFO write port and status pulses.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state          <= IDLE;
         wordCnt        <= 16'h0;
         dropFlag       <= 1'b0;
         bus.oFIFO_DATA <= 16'h0;
         bus.oFIFO_WR   <= 1'b0;
         oFRAME_DONE    <= 1'b0;
         oFULL_ERROR    <= 1'b0;
         oHEAD_ERROR    <= 1'b0;
         oEPILOG_ERROR  <= 1'b0;
      end else if (iSOFT_RST) begin
         // Soft clear abandons any frame in flight; the word this cycle is lost.
         state          <= IDLE;
         wordCnt        <= 16'h0;
         dropFlag       <= 1'b0;
         bus.oFIFO_DATA <= 16'h0;
         bus.oFIFO_WR   <= 1'b0;
         oFRAME_DONE    <= 1'b0;
         oFULL_ERROR    <= 1'b0;
         oHEAD_ERROR    <= 1'b0;
         oEPILOG_ERROR  <= 1'b0;
      end else begin
         bus.oFIFO_WR  <= 1'b0;
         oFRAME_DONE   <= 1'b0;
         oFULL_ERROR   <= 1'b0;
         oHEAD_ERROR   <= 1'b0;
         oEPILOG_ERROR <= 1'b0;
         if (bus.iDATA_VALID) begin
            case (state)
               IDLE: begin
                  if (bus.iDATA == HEAD_WORD) begin
                     state   <= PAYLOAD;
                     wordCnt <= 16'h0;
                  end else begin
                     oHEAD_ERROR <= 1'b1;
                  end
               end
               PAYLOAD: begin
                  // A header-valued word here is ordinary payload.
                  if (bus.iFIFO_FULL) begin
                     oFULL_ERROR <= 1'b1;
                     dropFlag    <= 1'b1;
                     state       <= DROP;
                  end else begin
                     bus.oFIFO_DATA <= bus.iDATA;
                     bus.oFIFO_WR   <= 1'b1;
                  end
                  wordCnt <= wordCnt + 16'h1;
                  // Last word overrides the DROP move: the epilog comes next.
                  if (lastWord) state <= EPILOG;
               end
               DROP: begin
                  wordCnt <= wordCnt + 16'h1;
                  if (lastWord) state <= EPILOG;
               end
               EPILOG: begin
                  if (bus.iDATA != EPILOG_WORD) begin
                     oEPILOG_ERROR <= 1'b1;
                  end else if (!dropFlag) begin
                     oFRAME_DONE <= 1'b1;
                  end
                  dropFlag <= 1'b0;
                  state    <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef BLVDS_FRAME_CHECK_STAT_EN
   logic frameDoneNext;

   // Same condition that raises oFRAME_DONE on the next edge.
   assign frameDoneNext = !iSOFT_RST && bus.iDATA_VALID && (state == EPILOG) &&
                          (bus.iDATA == EPILOG_WORD) && !dropFlag;

   // Saturating count of clean frames.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oFRAME_CNT <= 16'h0;
      end else if (iSOFT_RST) begin
         oFRAME_CNT <= 16'h0;
      end else if (frameDoneNext && (oFRAME_CNT != 16'hFFFF)) begin
         oFRAME_CNT <= oFRAME_CNT + 16'h1;
      end
   end
`endif

endmodule

// File: tb/tb_blvds_frame_check.sv
// tb_blvds_frame_check -- directed frames with PAYLOAD_LEN=4; expected FIFO
// writes and status pulses are queued as stimulus is issued and matched by
// an independent monitor on the falling edge.
module tb_blvds_frame_check;

   localparam int          PLEN = 4;
   localparam logic [15:0] HEAD = 16'hA5A5;
   localparam logic [15:0] EPI  = 16'h5A5A;

   localparam logic [3:0] EV_NONE = 4'd0;
   localparam logic [3:0] EV_WR   = 4'd1;
   localparam logic [3:0] EV_DONE = 4'd2;
   localparam logic [3:0] EV_FULL = 4'd3;
   localparam logic [3:0] EV_HEAD = 4'd4;
   localparam logic [3:0] EV_EPI  = 4'd5;

   // ---------------- clock / reset ----------------
   logic iCLK = 1'b0;
   logic iRST_N = 1'b0;
   logic iSOFT_RST = 1'b0;
   always #5 iCLK = ~iCLK;

   blvds_frame_check_if bus();

   logic       oFRAME_DONE, oFULL_ERROR, oHEAD_ERROR, oEPILOG_ERROR, oBUSY;
   logic [1:0] oDBG_STATE;
`ifdef BLVDS_FRAME_CHECK_STAT_EN
   logic [15:0] oFRAME_CNT;
`endif

   blvds_frame_check #(
      .HEAD_WORD  (HEAD),
      .EPILOG_WORD(EPI),
      .PAYLOAD_LEN(PLEN)
   ) dut (
      .iCLK         (iCLK),
      .iRST_N       (iRST_N),
      .iSOFT_RST    (iSOFT_RST),
      .bus          (bus),
      .oFRAME_DONE  (oFRAME_DONE),
      .oFULL_ERROR  (oFULL_ERROR),
      .oHEAD_ERROR  (oHEAD_ERROR),
      .oEPILOG_ERROR(oEPILOG_ERROR),
      .oBUSY        (oBUSY),
`ifdef BLVDS_FRAME_CHECK_STAT_EN
      .oFRAME_CNT   (oFRAME_CNT),
`endif
      .oDBG_STATE   (oDBG_STATE)
   );

   // ---------------- scoreboard ----------------
   logic [19:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int doneCount = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [15:0] d, input logic full, input logic [3:0] ev);
      @(posedge iCLK); #1;
      bus.iDATA       = d;
      bus.iDATA_VALID = 1'b1;
      bus.iFIFO_FULL  = full;
      if (ev != EV_NONE) exp_q.push_back({ev, (ev == EV_WR) ? d : 16'h0});
      if (ev == EV_DONE) doneCount++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge iCLK); #1;
         bus.iDATA_VALID = 1'b0;
         bus.iFIFO_FULL  = 1'b0;
      end
   endtask

   task automatic good_frame(input logic [15:0] base);
      send(HEAD, 1'b0, EV_NONE);
      for (int i = 0; i < PLEN; i++) send(base + 16'(i), 1'b0, EV_WR);
      send(EPI, 1'b0, EV_DONE);
   endtask

   // ---------------- monitor ----------------
   int          nOut;
   logic [19:0] obs;
   logic [19:0] expv;
   always @(negedge iCLK) begin
      if (iRST_N) begin
         nOut = int'(bus.oFIFO_WR) + int'(oFRAME_DONE) + int'(oFULL_ERROR) +
                int'(oHEAD_ERROR) + int'(oEPILOG_ERROR);
         if (nOut > 1) begin
            check("pulse_exclusive", 32'(nOut), 32'd1);
         end else if (nOut == 1) begin
            if (bus.oFIFO_WR)       obs = {EV_WR, bus.oFIFO_DATA};
            else if (oFRAME_DONE)   obs = {EV_DONE, 16'h0};
            else if (oFULL_ERROR)   obs = {EV_FULL, 16'h0};
            else if (oHEAD_ERROR)   obs = {EV_HEAD, 16'h0};
            else                    obs = {EV_EPI, 16'h0};
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(obs), 32'h0);
            end else begin
               expv = exp_q.pop_front();
               check("scoreboard", 32'(obs), 32'(expv));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.iDATA       = 16'h0;
      bus.iDATA_VALID = 1'b0;
      bus.iFIFO_FULL  = 1'b0;

      // Reset state
      repeat (2) @(posedge iCLK);
      #1;
      check("rst_busy",   32'(oBUSY), 32'd0);
      check("rst_wr",     32'(bus.oFIFO_WR), 32'd0);
      check("rst_data",   32'(bus.oFIFO_DATA), 32'd0);
      check("rst_pulses", 32'({oFRAME_DONE, oFULL_ERROR, oHEAD_ERROR, oEPILOG_ERROR}), 32'd0);
      check("rst_state",  32'(oDBG_STATE), 32'd0);
      iRST_N = 1'b1;
      idle(2);

      // Clean frame
      good_frame(16'h0001);
      idle(2);

      // Bad header word, then a clean frame with a gap between words
      send(16'h1234, 1'b0, EV_HEAD);
      send(HEAD, 1'b0, EV_NONE);
      send(16'h0011, 1'b0, EV_WR);
      idle(2);
      send(16'h0012, 1'b0, EV_WR);
      send(16'h0013, 1'b0, EV_WR);
      send(16'h0014, 1'b0, EV_WR);
      send(EPI, 1'b0, EV_DONE);
      idle(1);

      // FIFO full on word 2: rest of frame dropped, no done on epilog
      send(HEAD, 1'b0, EV_NONE);
      send(16'h0001, 1'b0, EV_WR);
      send(16'h0002, 1'b1, EV_FULL);
      send(16'h0003, 1'b0, EV_NONE);
      send(16'h0004, 1'b1, EV_NONE);
      send(EPI, 1'b0, EV_NONE);
      idle(1);
      good_frame(16'h0101);

      // Bad epilog, then next header accepted
      send(HEAD, 1'b0, EV_NONE);
      for (int i = 0; i < PLEN; i++) send(16'h0021 + 16'(i), 1'b0, EV_WR);
      send(16'hFFFF, 1'b0, EV_EPI);
      idle(1);
      check("epi_back_idle", 32'(oDBG_STATE), 32'd0);
      good_frame(16'h0031);

      // Header value inside payload is plain data
      send(HEAD, 1'b0, EV_NONE);
      send(HEAD, 1'b0, EV_WR);
      send(16'h0042, 1'b0, EV_WR);
      send(16'h0043, 1'b0, EV_WR);
      send(16'h0044, 1'b0, EV_WR);
      send(EPI, 1'b0, EV_DONE);

      // Full on last word, then matching epilog: no pulse on epilog
      send(HEAD, 1'b0, EV_NONE);
      send(16'h0051, 1'b0, EV_WR);
      send(16'h0052, 1'b0, EV_WR);
      send(16'h0053, 1'b0, EV_WR);
      send(16'h0054, 1'b1, EV_FULL);
      send(EPI, 1'b0, EV_NONE);

      // Dropped frame with a bad epilog still reports the epilog error
      send(HEAD, 1'b0, EV_NONE);
      send(16'h0061, 1'b1, EV_FULL);
      send(16'h0062, 1'b1, EV_NONE);
      send(16'h0063, 1'b0, EV_NONE);
      send(16'h0064, 1'b0, EV_NONE);
      send(16'h1111, 1'b0, EV_EPI);
      idle(2);

      // Asynchronous reset mid-frame takes effect immediately
      send(HEAD, 1'b0, EV_NONE);
      send(16'h0071, 1'b0, EV_WR);
      idle(1);
      @(posedge iCLK); #1;
      iRST_N = 1'b0;
      doneCount = 0;
      #1;
      check("arst_busy", 32'(oBUSY), 32'd0);
      check("arst_wr",   32'(bus.oFIFO_WR), 32'd0);
      @(posedge iCLK); #1;
      iRST_N = 1'b1;
      idle(1);

      // Three clean frames, then the soft-reset scenario
      good_frame(16'h0081);
      good_frame(16'h0091);
      good_frame(16'h00A1);
      idle(2);
`ifdef BLVDS_FRAME_CHECK_STAT_EN
      check("frame_cnt", 32'(oFRAME_CNT), 32'(doneCount));
`endif

      send(HEAD, 1'b0, EV_NONE);
      send(16'h0001, 1'b0, EV_WR);
      @(posedge iCLK); #1;
      bus.iDATA       = 16'h0002;
      bus.iDATA_VALID = 1'b1;
      iSOFT_RST       = 1'b1;
      @(posedge iCLK); #1;
      iSOFT_RST       = 1'b0;
      bus.iDATA_VALID = 1'b0;
      check("srst_busy",  32'(oBUSY), 32'd0);
      check("srst_state", 32'(oDBG_STATE), 32'd0);
`ifdef BLVDS_FRAME_CHECK_STAT_EN
      check("srst_frame_cnt", 32'(oFRAME_CNT), 32'd0);
`endif
      // Checker is back in IDLE: a payload word is now a header error
      send(16'h0003, 1'b0, EV_HEAD);
      good_frame(16'h00B1);
      idle(4);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/blvds_frame_check.md
BLVDS_FRAME_CHECK -- requirements
Module: blvds_frame_check

Interface
REQ-001 Parameter HEAD_WORD, default 16'hA5A5, frame header marker.
REQ-002 Parameter EPILOG_WORD, default 16'h5A5A, frame epilog marker.
REQ-003 Parameter PAYLOAD_LEN, default 256, payload words per frame, legal range 1..65535.
REQ-004 iCLK  in  1  single clock; all logic on posedge iCLK.
REQ-005 iRST_N  in  1  reset, asynchronous, active-low.
REQ-006 iSOFT_RST  in  1  synchronous clear, active-high, driven by the error-solver reset request.
REQ-007 iDATA  in  16  deserialized BLVDS word.
REQ-008 iDATA_VALID  in  1  iDATA valid this cycle.
REQ-009 iFIFO_FULL  in  1  downstream payload FIFO full.
REQ-010 oFIFO_DATA  out  16  payload word to FIFO.
REQ-011 oFIFO_WR  out  1  FIFO write strobe.
REQ-012 oFRAME_DONE  out  1  one-cycle pulse, frame completed cleanly.
REQ-013 oFULL_ERROR  out  1  one-cycle pulse, payload word lost to full FIFO.
REQ-014 oHEAD_ERROR  out  1  one-cycle pulse, header mismatch.
REQ-015 oEPILOG_ERROR  out  1  one-cycle pulse, epilog mismatch.
REQ-016 oBUSY  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, PAYLOAD, DROP, EPILOG; only words with iDATA_VALID=1 advance it.
REQ-018 IDLE: iDATA==HEAD_WORD -> PAYLOAD, word counter=0; any other valid word -> oHEAD_ERROR pulse, stay IDLE (one pulse per mismatched word).
REQ-019 PAYLOAD, iFIFO_FULL=0: register iDATA to oFIFO_DATA, oFIFO_WR=1 next cycle (latency 1), counter+1.
REQ-020 PAYLOAD, iFIFO_FULL=1: no write, oFULL_ERROR pulse, set drop flag, -> DROP, counter+1.
REQ-021 DROP: consume words without writing, no further oFULL_ERROR in this frame, counter+1.
REQ-022 Valid word with counter==PAYLOAD_LEN-1 in PAYLOAD or DROP -> EPILOG (after its own write/drop).
REQ-023 EPILOG: iDATA==EPILOG_WORD and drop flag=0 -> oFRAME_DONE pulse; iDATA!=EPILOG_WORD -> oEPILOG_ERROR pulse; either case -> IDLE, drop flag cleared.
REQ-024 Matching epilog with drop flag=1 -> IDLE, no pulse.
REQ-025 Header word received in PAYLOAD/DROP is treated as payload (no resync).
REQ-026 Counter 16-bit, never wraps within a frame; cleared on entry to PAYLOAD.
REQ-027 All pulse outputs registered, asserted exactly one cycle, mutually exclusive per input word.

Reset
REQ-028 iRST_N=0: FSM=IDLE, counter=0, drop flag=0, oFIFO_DATA=0, all 1-bit outputs 0, immediately.
REQ-029 iSOFT_RST=1: same values on next edge; input word that cycle discarded; soft reset wins over iDATA_VALID.
REQ-030 Reset mid-frame abandons the frame with no error or done pulse.

Configuration
REQ-031 Macro BLVDS_FRAME_CHECK_STAT_EN defined: adds output oFRAME_CNT[15:0], +1 per oFRAME_DONE, saturates at 16'hFFFF, cleared by iRST_N and iSOFT_RST.
REQ-032 Macro undefined: oFRAME_CNT port and counter absent; all other behaviour identical.

Verification (PAYLOAD_LEN=4)
REQ-033 A5A5,0001,0002,0003,0004,5A5A, FIFO never full -> 4 writes 0001..0004, one oFRAME_DONE, no errors.
REQ-034 1234 then good frame -> one oHEAD_ERROR on 1234, frame then accepted normally.
REQ-035 iFIFO_FULL=1 during word 2 -> writes only 0001, one oFULL_ERROR, words 3-4 dropped, no oFRAME_DONE on 5A5A.
REQ-036 Good payload, epilog FFFF -> 4 writes, one oEPILOG_ERROR, FSM back to IDLE, next A5A5 accepted.
REQ-037 iSOFT_RST=1 with valid word 0002 mid-frame -> no write of 0002, oBUSY=0 next cycle, no pulses.
REQ-038 STAT_EN: 3 good frames -> oFRAME_CNT=3; iSOFT_RST -> 0.
